// File: rtl/and_seq_pkg.sv
// and_seq_pkg: shared definitions for the tt_um_and_seq pin-driven logic-unit
// sequencer: operation codes, controller states, uio pin bit positions, the
// constant uio output-enable pattern and the bitwise operation helper.
package and_seq_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int STB_BIT   = 0;
  localparam int ACK_BIT   = 1;
  localparam int OP_LSB    = 2;
  localparam int BUSY_BIT  = 4;
  localparam int VALID_BIT = 5;
  localparam int WANTB_BIT = 6;
  localparam int ERR_BIT   = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  localparam int FIFO_DEPTH = 4;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input op_e op);
    logic [7:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_seq_sync.sv
// and_seq_sync: SYNC_STAGES-deep pin synchronizer followed by a registered
// rising-edge detector. The pulse is one clock wide and appears SYNC_STAGES+1
// clocks after the pin rises; it is masked while ena is low, so edges seen
// during that time are lost.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : pulse enable
//   din        : asynchronous pin input
//   pulse      : synchronous one-cycle rising-edge pulse
module and_seq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse = pulse_q & ena;

endmodule

// File: rtl/tt_um_and_seq.sv
// tt_um_and_seq: TinyTapeout top that sequences an 8-bit AND/OR/XOR/NAND unit.
// The host strobes operand A then operand B on ui_in (strobe = uio_in[0],
// op = uio_in[3:2]); the result is presented on uo_out until acknowledged
// (ack = uio_in[1]).
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design selected; strobe/ack edges ignored while low
//   ui_in      : operand byte
//   uio_in     : [0] strobe, [1] ack, [3:2] op, [7:4] unused
//   uo_out     : result byte
//   uio_out    : [4] busy, [5] res_valid, [6] want_b, [7] err (sticky)
//   uio_oe     : constant 8'hF0
// Optional build macro AND_SEQ_FIFO_EN: results queue into a 4-entry FIFO,
// HOLD is skipped, uo_out shows the FIFO head and ack pops one entry.
module tt_um_and_seq
  import and_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic   stb_p;
  logic   ack_p;
  state_e state;
  logic [7:0] a_q;
  logic [7:0] b_q;
  op_e        op_q;
  logic       err_q;

  logic unused_pins;
  assign unused_pins = &{1'b0, uio_in[7:4]};

  assign uio_oe = UIO_OE_VAL;

  and_seq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (uio_in[STB_BIT]),
    .pulse (stb_p)
  );

  and_seq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (uio_in[ACK_BIT]),
    .pulse (ack_p)
  );

`ifdef AND_SEQ_FIFO_EN

  localparam logic [2:0] FIFO_FULL = 3'(FIFO_DEPTH);

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;

  // Fullness is decided at the B strobe; since only EXEC pushes, a push
  // always finds a free slot.
  always_comb begin
    push = (state == EXEC);
    pop  = ack_p && (count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= alu(a_q, b_q, op_q);
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_AND;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_p) begin
            a_q   <= ui_in;
            state <= GOT_A;
          end
        end
        GOT_A: begin
          if (stb_p) begin
            if (count == FIFO_FULL) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              b_q   <= ui_in;
              op_q  <= op_e'(uio_in[OP_LSB +: OP_W]);
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (stb_p) err_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = fifo_mem[rd_ptr];
  assign uio_out = {err_q, (state == GOT_A), (count != '0), (state != IDLE), 4'b0000};

`else

  logic [7:0] res_q;
  logic       busy_q;
  logic       valid_q;
  logic       wantb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      wantb_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_p) begin
            a_q     <= ui_in;
            state   <= GOT_A;
            busy_q  <= 1'b1;
            wantb_q <= 1'b1;
          end
        end
        GOT_A: begin
          if (stb_p) begin
            b_q     <= ui_in;
            op_q    <= op_e'(uio_in[OP_LSB +: OP_W]);
            state   <= EXEC;
            wantb_q <= 1'b0;
          end
        end
        EXEC: begin
          if (stb_p) err_q <= 1'b1;
          res_q   <= alu(a_q, b_q, op_q);
          valid_q <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          // A strobe coinciding with ack still flags err; ack still wins.
          if (stb_p) err_q <= 1'b1;
          if (ack_p) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {err_q, wantb_q, valid_q, busy_q, 4'b0000};

`endif

endmodule

// File: tb/tb_tt_um_and_seq.sv
module tb_tt_um_and_seq;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];

  logic [7:0] exp_tab [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tt_um_and_seq #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Monitor: every new result presentation (rising res_valid) is compared
  // against the oldest expected entry, including the cycle it appeared on.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (uio_out[5] && !prev_v) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got %h at cycle %0d, required no result", uo_out, cyc);
        end else begin
          e = sb.pop_front();
          if (uo_out !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d",
                     uo_out, cyc, e.data, e.due);
          end
        end
      end
      prev_v = uio_out[5];
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Raise a pin, hold data/op stable, drop it and let the synchronizer settle.
  task automatic pulse_pin(input int bit_idx, input logic [7:0] data, input logic [1:0] op,
                           input bit push_exp, input logic [7:0] exp_val);
    exp_t e;
    @(negedge clk);
    ui_in          = data;
    uio_in[3:2]    = op;
    uio_in[bit_idx] = 1'b1;
    if (push_exp) begin
      e.data = exp_val;
      e.due  = cyc + S + 3;
      sb.push_back(e);
    end
    repeat (S + 3) @(negedge clk);
    uio_in[bit_idx] = 1'b0;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending results, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic op_seq(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input bit push_exp, input logic [7:0] exp_val);
    pulse_pin(0, a, 2'b00, 1'b0, 8'h00);
    check8("want_b_after_a", {7'b0, uio_out[6]}, 8'h01);
    pulse_pin(0, b, op, push_exp, exp_val);
    wait_drain("op");
`ifndef AND_SEQ_FIFO_EN
    check8("busy_in_hold", {7'b0, uio_out[4]}, 8'h01);
`endif
  endtask

  task automatic ack();
    pulse_pin(1, ui_in, uio_in[3:2], 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    repeat (3) @(negedge clk);
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef AND_SEQ_FIFO_EN
    for (int i = 0; i < 4; i++)
      op_seq(8'hF0, 8'h3C, 2'(i), (i == 0), exp_tab[i]);
    op_seq(8'hF0, 8'h3C, 2'b00, 1'b0, 8'h00);
    check8("fifo_full_err", {7'b0, uio_out[7]}, 8'h01);
    check8("fifo_full_busy", {7'b0, uio_out[4]}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check8("fifo_head", uo_out, exp_tab[i]);
      check8("fifo_valid", {7'b0, uio_out[5]}, 8'h01);
      ack();
    end
    check8("fifo_empty_valid", {7'b0, uio_out[5]}, 8'h00);
`else
    for (int i = 0; i < 4; i++) begin
      op_seq(8'hF0, 8'h3C, 2'(i), 1'b1, exp_tab[i]);
      ack();
      check8("valid_after_ack", {7'b0, uio_out[5]}, 8'h00);
      check8("uo_held_after_ack", uo_out, exp_tab[i]);
    end

    op_seq(8'h12, 8'h34, 2'b00, 1'b1, 8'h10);
    pulse_pin(0, 8'hAA, 2'b00, 1'b0, 8'h00);
    check8("err_hold_strobe", {7'b0, uio_out[7]}, 8'h01);
    check8("uo_after_hold_strobe", uo_out, 8'h10);
    check8("valid_after_hold_strobe", {7'b0, uio_out[5]}, 8'h01);
    ack();
    check8("valid_after_err_ack", {7'b0, uio_out[5]}, 8'h00);
    check8("busy_after_err_ack", {7'b0, uio_out[4]}, 8'h00);
    check8("err_sticky", {7'b0, uio_out[7]}, 8'h01);

    pulse_pin(0, 8'h0F, 2'b00, 1'b0, 8'h00);
    check8("want_b_before_reset", {7'b0, uio_out[6]}, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check8("midop_reset_uo_out", uo_out, 8'h00);
    check8("midop_reset_uio_out", uio_out, 8'h00);
    check8("midop_reset_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    op_seq(8'hFF, 8'h81, 2'b00, 1'b1, 8'h81);
    ack();

    ena = 1'b0;
    pulse_pin(0, 8'h55, 2'b00, 1'b0, 8'h00);
    check8("ena_low_busy", {7'b0, uio_out[4]}, 8'h00);
    check8("ena_low_want_b", {7'b0, uio_out[6]}, 8'h00);
    ena = 1'b1;
    pulse_pin(0, 8'h0F, 2'b00, 1'b0, 8'h00);
    check8("ena_high_want_b", {7'b0, uio_out[6]}, 8'h01);
    pulse_pin(0, 8'hF0, 2'b10, 1'b1, 8'hFF);
    wait_drain("ena_op");
    ack();
    check8("final_err_clear", {7'b0, uio_out[7]}, 8'h00);
    check8("final_valid", {7'b0, uio_out[5]}, 8'h00);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
